// File: rtl/mesm6_intc_pkg.sv
// Shared definitions for the MESM-6 interrupt controller: register map,
// FSM state encoding and vector width.
package mesm6_intc_pkg;

  localparam int VEC_W = 6;

  localparam logic [2:0] ADDR_PEND  = 3'o0;
  localparam logic [2:0] ADDR_MASK  = 3'o1;
  localparam logic [2:0] ADDR_INSVC = 3'o2;
  localparam logic [2:0] ADDR_VEC   = 3'o3;
  localparam logic [2:0] ADDR_EOI   = 3'o4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } intc_state_t;

endpackage

// File: rtl/mesm6_prio_enc.sv
// Lowest-set-bit priority encoder: reports whether any bit is set and the
// index of the lowest one.
module mesm6_prio_enc
  import mesm6_intc_pkg::*;
#(
  parameter int NIRQ = 8
) (
  input  logic [NIRQ-1:0]  req,
  output logic             found,
  output logic [VEC_W-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = VEC_W'(i);
      end
    end
  end

endmodule

// File: rtl/mesm6_intc.sv
// MESM-6 interrupt controller: pending/mask/in-service registers, a
// lowest-index-wins request to the CPU and an ack/EOI handshake.
// Build option: define MESM6_INTC_EDGE_EN for rising-edge capture of the
// sources; without it PEND simply tracks the registered source levels.
//
// state   | meaning
// IDLE    | no request outstanding, waiting for an unmasked pending source
// REQ     | cpu_irq asserted, cpu_vector frozen, waiting for ack
// SERVICE | interrupt acknowledged, INSVC set, waiting for EOI write
module mesm6_intc
  import mesm6_intc_pkg::*;
#(
  parameter int NIRQ = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NIRQ-1:0]  irq_src,
  output logic             cpu_irq,
  output logic [VEC_W-1:0] cpu_vector,
  input  logic             cpu_ack,
  input  logic [14:0]      intc_addr,
  input  logic             intc_read,
  input  logic             intc_write,
  output logic [47:0]      intc_rdata,
  input  logic [47:0]      intc_wdata,
  output logic             intc_done
);

  intc_state_t      state;
  logic [NIRQ-1:0]  src_q;
  logic [NIRQ-1:0]  pend;
  logic [NIRQ-1:0]  mask;
  logic [NIRQ-1:0]  insvc;
  logic [NIRQ-1:0]  vec_onehot;
  logic [NIRQ-1:0]  wdata_n;
  logic             win_found;
  logic [VEC_W-1:0] win_idx;
  logic             vec_live;
  logic             wr_mask;
  logic             wr_eoi;
  logic             unused_bits;

  assign wdata_n     = intc_wdata[NIRQ-1:0];
  assign wr_mask     = intc_write && (intc_addr[2:0] == ADDR_MASK);
  assign wr_eoi      = intc_write && (intc_addr[2:0] == ADDR_EOI);
  assign unused_bits = ^{intc_addr[14:3], intc_wdata};

  mesm6_prio_enc #(.NIRQ(NIRQ)) u_prio (
    .req   (pend & mask),
    .found (win_found),
    .idx   (win_idx)
  );

  // Decode the latched vector so it can address PEND/INSVC bitwise.
  always_comb begin
    vec_onehot = '0;
    for (int i = 0; i < NIRQ; i++) begin
      vec_onehot[i] = (cpu_vector == VEC_W'(i));
    end
  end

  assign vec_live = |(pend & mask & vec_onehot);

  // Register the raw request lines once before they reach PEND.
  always_ff @(posedge clk) begin
    if (reset) src_q <= '0;
    else       src_q <= irq_src;
  end

`ifdef MESM6_INTC_EDGE_EN
  logic [NIRQ-1:0] prev_q;
  logic [NIRQ-1:0] rise;
  logic [NIRQ-1:0] w1c;
  logic [NIRQ-1:0] ack_clr;

  assign rise    = src_q & ~prev_q;
  assign w1c     = (intc_write && (intc_addr[2:0] == ADDR_PEND)) ? wdata_n : '0;
  assign ack_clr = (state == REQ && cpu_ack) ? vec_onehot : '0;

  // Edge capture; a new rising edge wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= '0;
      pend   <= '0;
    end else begin
      prev_q <= src_q;
      pend   <= (pend & ~w1c & ~ack_clr) | rise;
    end
  end
`else
  // Level mode: PEND mirrors the registered sources; W1C and ack do nothing.
  always_ff @(posedge clk) begin
    if (reset) pend <= '0;
    else       pend <= src_q;
  end
`endif

  // Mask register and the zero-wait-state bus completion strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask      <= '0;
      intc_done <= 1'b0;
    end else begin
      if (wr_mask) mask <= wdata_n;
      intc_done <= intc_read | intc_write;
    end
  end

  // Request/ack/EOI sequencing; cpu_irq, cpu_vector and INSVC are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cpu_irq    <= 1'b0;
      cpu_vector <= '0;
      insvc      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found && insvc == '0) begin
            cpu_vector <= win_idx;
            cpu_irq    <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (cpu_ack) begin
            insvc   <= vec_onehot;
            cpu_irq <= 1'b0;
            state   <= SERVICE;
          end else if (!vec_live) begin
            cpu_irq <= 1'b0;
            state   <= IDLE;
          end
        end
        SERVICE: begin
          if (wr_eoi) begin
            insvc <= '0;
            state <= IDLE;
          end
        end
        default: begin
          cpu_irq <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Read mux; registers narrower than the bus are zero-extended.
  always_comb begin
    logic [47:0] pend_x;
    logic [47:0] mask_x;
    logic [47:0] insvc_x;
    pend_x              = '0;
    mask_x              = '0;
    insvc_x             = '0;
    pend_x[NIRQ-1:0]    = pend;
    mask_x[NIRQ-1:0]    = mask;
    insvc_x[NIRQ-1:0]   = insvc;
    intc_rdata          = '0;
    case (intc_addr[2:0])
      ADDR_PEND:  intc_rdata = pend_x;
      ADDR_MASK:  intc_rdata = mask_x;
      ADDR_INSVC: intc_rdata = insvc_x;
      ADDR_VEC:   intc_rdata = {cpu_irq, {(48-VEC_W-1){1'b0}}, cpu_vector};
      default:    intc_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_mesm6_intc.sv
// Self-checking bench for mesm6_intc; expectations adapt to MESM6_INTC_EDGE_EN.
module tb_mesm6_intc;
  import mesm6_intc_pkg::*;

  localparam int NIRQ = 8;
`ifdef MESM6_INTC_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [NIRQ-1:0]  irq_src;
  logic             cpu_irq;
  logic [VEC_W-1:0] cpu_vector;
  logic             cpu_ack;
  logic [14:0]      intc_addr;
  logic             intc_read;
  logic             intc_write;
  logic [47:0]      intc_rdata;
  logic [47:0]      intc_wdata;
  logic             intc_done;

  typedef struct {
    bit          is_read;
    logic [47:0] data;
    string       tag;
  } bus_exp_t;

  bus_exp_t         bus_q[$];
  logic [VEC_W-1:0] vec_q[$];
  bus_exp_t         bus_e;
  logic [VEC_W-1:0] vec_e;
  logic             irq_d = 1'b0;
  int               n_checks = 0;
  int               n_errors = 0;

  mesm6_intc #(.NIRQ(NIRQ)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_src    (irq_src),
    .cpu_irq    (cpu_irq),
    .cpu_vector (cpu_vector),
    .cpu_ack    (cpu_ack),
    .intc_addr  (intc_addr),
    .intc_read  (intc_read),
    .intc_write (intc_write),
    .intc_rdata (intc_rdata),
    .intc_wdata (intc_wdata),
    .intc_done  (intc_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: bus completions and new CPU requests pop their expectations.
  always @(negedge clk) begin
    if (intc_done) begin
      if (bus_q.size() == 0) chk("done_unexpected", 48'(bus_q.size()), 48'd1);
      else begin
        bus_e = bus_q.pop_front();
        if (bus_e.is_read) chk(bus_e.tag, intc_rdata, bus_e.data);
      end
    end
    if (cpu_irq && !irq_d) begin
      if (vec_q.size() == 0) chk("irq_unexpected", 48'(vec_q.size()), 48'd1);
      else begin
        vec_e = vec_q.pop_front();
        chk("irq_vector", 48'(cpu_vector), 48'(vec_e));
      end
    end
    irq_d <= cpu_irq;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [47:0] d);
    bus_q.push_back('{is_read: 1'b0, data: 48'd0, tag: "wr"});
    intc_addr  = {12'd0, a};
    intc_wdata = d;
    intc_write = 1'b1;
    step();
    intc_write = 1'b0;
    chk("wr_done", 48'(intc_done), 48'd1);
    step();
    chk("wr_done_clr", 48'(intc_done), 48'd0);
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [47:0] exp, input string tag);
    bus_q.push_back('{is_read: 1'b1, data: exp, tag: tag});
    intc_addr = {12'd0, a};
    intc_read = 1'b1;
    step();
    intc_read = 1'b0;
    chk("rd_done", 48'(intc_done), 48'd1);
    step();
    chk("rd_done_clr", 48'(intc_done), 48'd0);
  endtask

  task automatic peek(input logic [2:0] a, input logic [47:0] exp, input string tag);
    intc_addr = {12'd0, a};
    #1;
    chk(tag, intc_rdata, exp);
  endtask

  // Edge mode gets a one-cycle pulse; level mode keeps the line high.
  task automatic raise(input logic [NIRQ-1:0] bits);
    irq_src = irq_src | bits;
    step();
    if (EDGE) irq_src = irq_src & ~bits;
  endtask

  task automatic release_src(input logic [NIRQ-1:0] bits);
    irq_src = irq_src & ~bits;
    repeat (3) step();
  endtask

  task automatic ack();
    cpu_ack = 1'b1;
    step();
    cpu_ack = 1'b0;
    chk("irq_after_ack", 48'(cpu_irq), 48'd0);
  endtask

  task automatic wait_irq(input string tag);
    for (int i = 0; i < 20 && !cpu_irq; i++) step();
    chk(tag, 48'(cpu_irq), 48'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; irq_src = '0; cpu_ack = 1'b0;
    intc_addr = '0; intc_read = 1'b0; intc_write = 1'b0; intc_wdata = '0;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Reset state
    chk("rst_irq", 48'(cpu_irq), 48'd0);
    chk("rst_vec", 48'(cpu_vector), 48'd0);
    chk("rst_done", 48'(intc_done), 48'd0);
    bus_read(ADDR_PEND, 48'd0, "rst_pend");
    bus_read(ADDR_MASK, 48'd0, "rst_mask");
    bus_read(ADDR_INSVC, 48'd0, "rst_insvc");
    bus_read(ADDR_VEC, 48'd0, "rst_vecreg");

    // Single source 3 with exact request latency
    bus_write(ADDR_MASK, 48'hFF);
    vec_q.push_back(6'd3);
    raise(8'h08);
    step();
    chk("lat_n1_irq", 48'(cpu_irq), 48'd0);
    step();
    chk("lat_n2_irq", 48'(cpu_irq), 48'd1);
    bus_read(ADDR_PEND, 48'h08, "s1_pend");
    bus_read(ADDR_VEC, 48'h8000_0000_0003, "s1_vecreg");
    ack();
    bus_read(ADDR_INSVC, 48'h08, "s1_insvc");
    bus_read(ADDR_PEND, EDGE ? 48'h00 : 48'h08, "s1_pend_ack");
    cpu_ack = 1'b1; step(); cpu_ack = 1'b0;
    bus_read(ADDR_INSVC, 48'h08, "s1_ack_in_svc");
    release_src(8'h08);
    bus_write(ADDR_EOI, 48'h0);
    bus_read(ADDR_INSVC, 48'd0, "s1_insvc_eoi");
    bus_read(ADDR_VEC, 48'h3, "s1_vec_idle");

    // Sources 5 and 1 together: 1 first, then 5
    vec_q.push_back(6'd1);
    raise(8'h22);
    wait_irq("s2_irq1");
    ack();
    release_src(8'h02);
    bus_read(ADDR_PEND, 48'h20, "s2_pend");
    vec_q.push_back(6'd5);
    bus_write(ADDR_EOI, 48'h0);
    wait_irq("s2_irq5");
    ack();
    release_src(8'h20);
    bus_write(ADDR_EOI, 48'h0);

    // Withdraw by mask write, re-raise, and vector stability in REQ
    vec_q.push_back(6'd2);
    raise(8'h04);
    wait_irq("s3_irq2");
    bus_write(ADDR_MASK, 48'h0);
    chk("s3_withdraw", 48'(cpu_irq), 48'd0);
    bus_read(ADDR_VEC, 48'h2, "s3_vecreg");
    vec_q.push_back(6'd2);
    bus_write(ADDR_MASK, 48'hFF);
    wait_irq("s3_reraise");
    raise(8'h01);
    repeat (3) step();
    chk("s3_hold_vec", 48'(cpu_vector), 48'd2);
    chk("s3_hold_irq", 48'(cpu_irq), 48'd1);
    ack();
    release_src(8'h04);
    vec_q.push_back(6'd0);
    bus_write(ADDR_EOI, 48'h0);
    wait_irq("s3_irq0");
    ack();
    release_src(8'h01);
    bus_write(ADDR_EOI, 48'h0);

    // W1C colliding with a new rising edge on source 4
    bus_write(ADDR_MASK, 48'h0);
    irq_src[4] = 1'b1;
    step();
    bus_write(ADDR_PEND, 48'h10);
    bus_read(ADDR_PEND, 48'h10, "s4_set_beats_clr");
    bus_write(ADDR_PEND, 48'h10);
    bus_read(ADDR_PEND, EDGE ? 48'h00 : 48'h10, "s4_w1c_alone");
    release_src(8'h10);
    bus_read(ADDR_PEND, 48'h00, "s4_pend_end");

    // Reset in SERVICE with PEND=0x06, source 0 held across release
    bus_write(ADDR_MASK, 48'hFF);
    vec_q.push_back(6'd1);
    raise(8'h06);
    wait_irq("s5_irq1");
    ack();
    if (EDGE) raise(8'h02);
    repeat (2) step();
    bus_read(ADDR_PEND, 48'h06, "s5_pend");
    bus_read(ADDR_INSVC, 48'h02, "s5_insvc");
    reset = 1'b1;
    irq_src = 8'h01;
    repeat (2) step();
    chk("s5_rst_irq", 48'(cpu_irq), 48'd0);
    chk("s5_rst_vec", 48'(cpu_vector), 48'd0);
    chk("s5_rst_done", 48'(intc_done), 48'd0);
    peek(ADDR_PEND, 48'd0, "s5_rst_pend");
    peek(ADDR_MASK, 48'd0, "s5_rst_mask");
    peek(ADDR_INSVC, 48'd0, "s5_rst_insvc");
    peek(ADDR_VEC, 48'd0, "s5_rst_vecreg");
    reset = 1'b0;
    step();
    peek(ADDR_PEND, 48'd0, "s5_pend_r1");
    step();
    peek(ADDR_PEND, 48'h01, "s5_pend_r2");
    release_src(8'h01);
    bus_write(ADDR_PEND, 48'hFF);
    bus_read(ADDR_PEND, 48'h00, "s5_pend_clr");

    // Bus decode, reserved addresses and bits above NIRQ
    bus_write(ADDR_MASK, 48'h5A);
    bus_read(ADDR_MASK, 48'h5A, "s6_mask");
    bus_read(3'o6, 48'd0, "s6_rsvd6");
    bus_write(3'o7, 48'hFFFF_FFFF_FFFF);
    bus_read(ADDR_MASK, 48'h5A, "s6_mask_after7");
    bus_read(3'o7, 48'd0, "s6_rsvd7");
    bus_read(ADDR_EOI, 48'd0, "s6_eoi_rd");
    bus_write(ADDR_MASK, 48'hFFFF_FFFF_FFFF);
    bus_read(ADDR_MASK, 48'hFF, "s6_mask_width");
    chk("s6_no_irq", 48'(cpu_irq), 48'd0);

    step();
    chk("bus_q_drained", 48'(bus_q.size()), 48'd0);
    chk("vec_q_drained", 48'(vec_q.size()), 48'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
